trng_csr_ctrl: RTL and testbench
================================

TRNG_CSR_CTRL -- requirements
Module: trng_csr_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: bus data width and DATA word width in bits; it SHALL be a multiple of BYTE_WIDTH.
REQ-002 Parameter BYTE_WIDTH, default 8: byte-lane width for write strobes.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port bus_addr, input, 2: word index (0 CTRL, 1 STATUS, 2 DATA, 3 reserved).
REQ-006 Port bus_we, input, WIDTH/BYTE_WIDTH: per-byte write strobes.
REQ-007 Port bus_wdata, input, WIDTH: write data.
REQ-008 Port bus_re, input, 1: read request.
REQ-009 Port bus_rdata, output, WIDTH: registered read data.
REQ-010 Port bus_rvalid, output, 1: high for exactly one cycle when bus_rdata is valid.
REQ-011 Port rnd_bit, input, 1: raw entropy bit from the source.
REQ-012 Port irq, output, 1: level interrupt, equal to STATUS.valid AND CTRL.irq_en.

Function
REQ-013 CTRL fields SHALL be: bit0 enable, bit1 cont (continuous mode), bit2 irq_en, bits[15:8] div. All other bits SHALL read 0.
REQ-014 CTRL SHALL be writable per byte lane: only lanes with bus_we set update.
REQ-015 STATUS SHALL be: bit0 valid (read-only), bit1 overrun (write-1-to-clear via lane 0), bits[9:4] bit_cnt (read-only).
REQ-016 Writes to DATA, reserved addresses and read-only fields SHALL be ignored.
REQ-017 Read latency SHALL be 1 cycle: bus_re in cycle N gives bus_rdata and bus_rvalid in cycle N+1. Address 3 SHALL read 0.
REQ-018 bus_re and bus_we asserted in the same cycle SHALL return the pre-write value.
REQ-019 A DATA read SHALL clear valid in the cycle after the request.
REQ-020 FSM states SHALL be IDLE, COLLECT and WAIT_READ.
REQ-021 IDLE -> COLLECT when enable=1. Any state -> IDLE when enable=0; the partial word, bit_cnt and the divider counter SHALL clear. DATA, valid and overrun SHALL be kept.
REQ-022 In COLLECT, a divider counter SHALL count 0..div, and rnd_bit SHALL be sampled when the count equals div (every div+1 cycles). div=0 SHALL sample every cycle.
REQ-023 Each sampled bit SHALL shift into the shift register LSB-first (the first bit ends at bit0) and increment bit_cnt.
REQ-024 On the WIDTH-th sample: the word SHALL be copied to DATA, valid set, bit_cnt cleared.
REQ-025 On word completion with cont=0: the FSM SHALL go to WAIT_READ. It SHALL return to COLLECT on the cycle after a DATA read.
REQ-026 On word completion with cont=1: the FSM SHALL stay in COLLECT. If valid was already 1 and no DATA read occurs in that cycle, DATA SHALL be overwritten and overrun set.
REQ-027 A DATA read in the same cycle as word completion SHALL return the old word, load the new word, leave valid=1 and not set overrun.
REQ-028 A STATUS overrun clear in the same cycle as a new overrun event SHALL leave overrun=1.
REQ-029 Sampling SHALL not occur in IDLE or WAIT_READ.

Reset
REQ-030 On rst=1 at a clock edge, all registers, the shift register, counters, bus_rdata, bus_rvalid and irq SHALL be 0, and the FSM SHALL be in IDLE.
REQ-031 Reset mid-collection or mid-read SHALL discard the partial word and suppress the pending bus_rvalid.

Structure
REQ-032 A shared package trng_pkg SHALL hold the address constants, CTRL/STATUS bit positions and the FSM state enum.
REQ-033 CTRL SHALL be one instance of the team's byte_write_reg module; the remaining logic SHALL be in trng_csr_ctrl.

Verification
REQ-034 Reset, then read all addresses -> each read returns 0 one cycle later with bus_rvalid for one cycle.
REQ-035 Write CTRL=0x0000_0001 (div=0, cont=0) and drive rnd_bit pattern 0xA5A5_1234 LSB-first -> after 32 cycles valid=1 and DATA=0xA5A5_1234; no sampling until DATA is read.
REQ-036 Write CTRL lane 1 only with 0x0300 -> div=3, enable unchanged; new samples occur every 4 cycles (a 32-bit word takes 128 cycles).
REQ-037 cont=1, no reads for two words -> overrun=1 and DATA holds the second word; writing STATUS=0x2 clears overrun.
REQ-038 DATA read in the same cycle as word completion -> old word returned, new word loaded, valid=1, overrun=0.
REQ-039 Clear enable at bit_cnt=17 -> FSM goes to IDLE and bit_cnt reads 0. Re-enable -> the next word consists of 32 fresh bits.

Source files
------------

// File: rtl/trng_pkg.sv
// TRNG CSR controller shared definitions: register addresses,
// CTRL/STATUS field positions and the collector FSM states.
package trng_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DATA   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CONT    = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_DIV_LSB = 8;
  localparam int CTRL_DIV_MSB = 15;

  localparam int ST_VALID   = 0;
  localparam int ST_OVR     = 1;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_MSB = 9;

  localparam int CNT_W = ST_CNT_MSB - ST_CNT_LSB + 1;
  localparam int DIV_W = CTRL_DIV_MSB - CTRL_DIV_LSB + 1;

  // Implemented CTRL bits: enable, cont, irq_en, div.
  localparam logic [31:0] CTRL_WMASK = 32'h0000_FF07;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WAIT_READ
  } state_t;

endpackage

// File: rtl/byte_write_reg.sv
// Register with per-byte-lane write strobes and a writable-bit mask.
// Ports: clk, rst (sync, active-high), i_we lanes, i_wdata, o_q.
module byte_write_reg #(
  parameter int              WIDTH      = 32,
  parameter int              BYTE_WIDTH = 8,
  parameter logic [WIDTH-1:0] MASK      = '1,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH/BYTE_WIDTH-1:0] i_we,
  input  logic [WIDTH-1:0]            i_wdata,
  output logic [WIDTH-1:0]            o_q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_bit_we;

  always_comb begin
    w_bit_we = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bit_we[i] = i_we[i / BYTE_WIDTH];
    end
  end

  // Unimplemented bits stay 0 because the mask strips them on write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= (r_q & ~w_bit_we) | (i_wdata & w_bit_we & MASK);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/trng_csr_ctrl.sv
// TRNG collector with CSR bus: samples rnd_bit every div+1 cycles into
// a word, publishes it in DATA. Ports: clk, rst, bus_*, rnd_bit, irq.
module trng_csr_ctrl
  import trng_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  bus_addr,
  input  logic [WIDTH/BYTE_WIDTH-1:0] bus_we,
  input  logic [WIDTH-1:0]            bus_wdata,
  input  logic                        bus_re,
  output logic [WIDTH-1:0]            bus_rdata,
  output logic                        bus_rvalid,
  input  logic                        rnd_bit,
  output logic                        irq
);

  localparam int NB = WIDTH / BYTE_WIDTH;
  localparam logic [WIDTH-1:0] W_MASK = WIDTH'(CTRL_WMASK);

  logic [NB-1:0]    w_ctrl_we;
  logic [WIDTH-1:0] w_ctrl;
  logic             w_en;
  logic             w_cont;
  logic [DIV_W-1:0] w_div;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-2:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovr;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;

  logic             w_sample;
  logic             w_last;
  logic             w_data_rd;
  logic             w_ovr_clr;
  logic [WIDTH-1:0] w_status;
  logic [WIDTH-1:0] w_rd_mux;

  assign w_ctrl_we = (bus_addr == ADDR_CTRL) ? bus_we : '0;

  byte_write_reg #(
    .WIDTH      (WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .MASK       (W_MASK),
    .RST_VAL    ('0)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_ctrl_we),
    .i_wdata (bus_wdata),
    .o_q     (w_ctrl)
  );

  assign w_en   = w_ctrl[CTRL_EN];
  assign w_cont = w_ctrl[CTRL_CONT];
  assign w_div  = w_ctrl[CTRL_DIV_MSB:CTRL_DIV_LSB];

  // >= keeps the divider from running away if div shrinks mid-count.
  assign w_sample  = (r_state == S_COLLECT) && w_en &&
                     (r_div_cnt >= w_div);
  assign w_last    = w_sample &&
                     (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_data_rd = bus_re && (bus_addr == ADDR_DATA);
  assign w_ovr_clr = (bus_addr == ADDR_STATUS) && bus_we[0] &&
                     bus_wdata[ST_OVR];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!w_en) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:      w_next = S_COLLECT;
        S_COLLECT:   if (w_last && !w_cont) w_next = S_WAIT_READ;
        S_WAIT_READ: if (w_data_rd) w_next = S_COLLECT;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
    end else if (!w_en) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
    end else if (r_state == S_COLLECT) begin
      if (w_sample) begin
        r_div_cnt <= '0;
        if (w_last) begin
          r_shift   <= '0;
          r_bit_cnt <= '0;
        end else begin
          r_shift   <= {rnd_bit, r_shift[WIDTH-2:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end else begin
      r_div_cnt <= '0;
    end
  end

  // Completion wins over a same-cycle DATA read; a new overrun
  // event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_last) r_data <= {rnd_bit, r_shift};
      if (w_last)         r_valid <= 1'b1;
      else if (w_data_rd) r_valid <= 1'b0;
      if (w_last && r_valid && !w_data_rd) r_ovr <= 1'b1;
      else if (w_ovr_clr)                  r_ovr <= 1'b0;
    end
  end

  always_comb begin
    w_status = '0;
    w_status[ST_VALID] = r_valid;
    w_status[ST_OVR]   = r_ovr;
    w_status[ST_CNT_MSB:ST_CNT_LSB] = r_bit_cnt;
  end

  always_comb begin
    w_rd_mux = '0;
    unique case (bus_addr)
      ADDR_CTRL:   w_rd_mux = w_ctrl;
      ADDR_STATUS: w_rd_mux = w_status;
      ADDR_DATA:   w_rd_mux = r_data;
      ADDR_RSVD:   w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rdata  <= bus_re ? w_rd_mux : '0;
      r_rvalid <= bus_re;
    end
  end

  assign bus_rdata  = r_rdata;
  assign bus_rvalid = r_rvalid;
  assign irq        = r_valid & w_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_trng_csr_ctrl.sv
// Self-checking bench for trng_csr_ctrl: directed bus steps, random
// entropy bits, cycle-level behavioural reference model.
module tb_trng_csr_ctrl;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  bus_addr = '0;
  logic [3:0]  bus_we = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        rnd_bit = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  trng_csr_ctrl #(.WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_wdata  (bus_wdata),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .rnd_bit    (rnd_bit),
    .irq        (irq)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 0 idle, 1 collecting, 2 waiting for DATA read.
  logic [31:0] m_ctrl = '0;
  int          m_st = 0;
  int          m_phase = 0;
  int          m_nbits = 0;
  logic [31:0] m_word = '0;
  logic [31:0] m_data = '0;
  bit          m_valid = 0;
  bit          m_ovr = 0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_words[$];

  bit          pat_mode = 0;
  logic [31:0] pat = '0;

  function automatic logic [31:0] m_read_val(input logic [1:0] a);
    case (a)
      2'd0: return m_ctrl;
      2'd1: return (32'(m_nbits) << 4) | (32'(m_ovr) << 1) |
                   32'(m_valid);
      2'd2: return m_data;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit en, cont, smp, done, rd_data, ovr_set, ovr_clr;
    int div;
    if (rst) begin
      m_ctrl = '0; m_st = 0; m_phase = 0; m_nbits = 0;
      m_word = '0; m_data = '0; m_valid = 0; m_ovr = 0;
      m_rdata = '0;
    end else begin
      en   = m_ctrl[0];
      cont = m_ctrl[1];
      div  = int'(m_ctrl[15:8]);
      rd_data = bus_re && (bus_addr == 2'd2);
      m_rdata = bus_re ? m_read_val(bus_addr) : 32'h0;
      done = 0;
      if (!en) begin
        m_st = 0; m_word = '0; m_nbits = 0; m_phase = 0;
      end else begin
        case (m_st)
          0: begin m_st = 1; m_phase = 0; end
          1: begin
            smp = ((m_phase + 1) % (div + 1)) == 0;
            m_phase++;
            if (smp) begin
              m_word[m_nbits] = rnd_bit;
              m_nbits++;
              if (m_nbits == W) begin
                done = 1;
                m_words.push_back(m_word);
                m_data = m_word;
                m_word = '0; m_nbits = 0; m_phase = 0;
                if (!cont) m_st = 2;
              end
            end
          end
          default: if (rd_data) begin m_st = 1; m_phase = 0; end
        endcase
      end
      ovr_set = done && m_valid && !rd_data;
      ovr_clr = (bus_addr == 2'd1) && bus_we[0] && bus_wdata[1];
      if (ovr_set)      m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
      if (done)         m_valid = 1;
      else if (rd_data) m_valid = 0;
      for (int b = 0; b < 4; b++)
        if (bus_addr == 2'd0 && bus_we[b])
          m_ctrl[b*8 +: 8] = bus_wdata[b*8 +: 8];
      m_ctrl = m_ctrl & 32'h0000_FF07;
    end
  end

  initial begin : entropy
    forever begin
      @(negedge clk);
      rnd_bit = pat_mode ? pat[m_nbits] : 1'($urandom);
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] we,
                    input logic [31:0] d, input bit now);
    if (!now) @(negedge clk);
    bus_addr = a; bus_we = we; bus_wdata = d;
    @(negedge clk);
    bus_we = '0; bus_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, input string tag,
                    input bit now, output logic [31:0] d);
    if (!now) @(negedge clk);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus_rvalid), 32'd1);
    chk({tag, "_rdata"}, bus_rdata, m_rdata);
    chk({tag, "_irq"}, 32'(irq), 32'(m_valid & m_ctrl[2]));
    d = bus_rdata;
    @(negedge clk);
    chk({tag, "_rvalid_1cyc"}, 32'(bus_rvalid), 32'd0);
  endtask

  task automatic wait_bits(input int k, input string tag);
    bit hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = (m_nbits == k) && (m_st == 1);
    end
    chk({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  initial begin : main
    logic [31:0] d;
    logic [31:0] old_word;
    int base;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rvalid", 32'(bus_rvalid), 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), "rst_read", 0, d);
      chk("rst_read_zero", d, 32'd0);
    end

    // One-shot word, div=0, fixed pattern.
    pat_mode = 1; pat = 32'hA5A5_1234;
    wr(2'd0, 4'hF, 32'h0000_0001, 0);
    repeat (40) @(negedge clk);
    rd(2'd1, "oneshot_status", 0, d);
    chk("oneshot_status_val", d, 32'h0000_0001);
    repeat (20) @(negedge clk);
    rd(2'd1, "oneshot_hold", 0, d);
    chk("oneshot_no_sample", d, 32'h0000_0001);

    // Lane 1 only: div=3, enable untouched.
    wr(2'd0, 4'b0010, 32'hFFFF_03FF, 0);
    rd(2'd0, "ctrl_lane1", 0, d);
    chk("ctrl_lane1_val", d, 32'h0000_0301);
    pat = 32'h0F1E_2D3C;
    rd(2'd2, "oneshot_data", 0, d);
    chk("oneshot_data_val", d, 32'hA5A5_1234);
    repeat (100) @(negedge clk);
    rd(2'd1, "div3_mid", 0, d);
    chk("div3_not_done", 32'(d[0]), 32'd0);
    repeat (40) @(negedge clk);
    rd(2'd1, "div3_status", 0, d);
    chk("div3_valid", 32'(d[0]), 32'd1);
    rd(2'd2, "div3_data", 0, d);
    chk("div3_data_val", d, 32'h0F1E_2D3C);

    // Continuous mode, two words unread -> overrun.
    wr(2'd0, 4'hF, 32'h0, 0);
    pat_mode = 0;
    base = m_words.size();
    wr(2'd0, 4'hF, 32'h0000_0007, 0);
    repeat (75) @(negedge clk);
    rd(2'd1, "cont_status", 0, d);
    chk("cont_overrun", 32'(d[1]), 32'd1);
    rd(2'd2, "cont_data", 0, d);
    chk("cont_word2", d, m_words[base + 1]);
    wr(2'd0, 4'hF, 32'h0, 0);
    wr(2'd1, 4'b0001, 32'h0000_0002, 0);
    rd(2'd1, "ovr_clear", 0, d);
    chk("ovr_cleared", 32'(d[1]), 32'd0);

    // DATA read colliding with word completion.
    rd(2'd2, "pre_collide", 0, d);
    wr(2'd0, 4'hF, 32'h0000_0003, 0);
    wait_bits(31, "collide_w1");
    repeat (2) @(negedge clk);
    wait_bits(31, "collide_w2");
    old_word = m_data;
    rd(2'd2, "collide", 1, d);
    chk("collide_old_word", d, old_word);
    rd(2'd1, "collide_status", 0, d);
    chk("collide_valid", 32'(d[0]), 32'd1);
    chk("collide_no_ovr", 32'(d[1]), 32'd0);
    rd(2'd2, "collide_new", 0, d);
    chk("collide_new_word", d, m_words[m_words.size() - 1]);

    // Disable mid-word, then a fresh word.
    wr(2'd0, 4'hF, 32'h0, 0);
    rd(2'd2, "pre_abort", 0, d);
    wr(2'd0, 4'hF, 32'h0000_0001, 0);
    wait_bits(17, "abort_at17");
    wr(2'd0, 4'hF, 32'h0, 1);
    repeat (2) @(negedge clk);
    rd(2'd1, "abort_status", 0, d);
    chk("abort_cnt_zero", d & 32'h0000_03F0, 32'd0);
    pat_mode = 1; pat = 32'h5A5A_C3C3;
    wr(2'd0, 4'hF, 32'h0000_0001, 0);
    repeat (40) @(negedge clk);
    rd(2'd1, "fresh_status", 0, d);
    chk("fresh_status_val", d, 32'h0000_0001);
    rd(2'd2, "fresh_data", 0, d);
    chk("fresh_data_val", d, 32'h5A5A_C3C3);

    // Reset while collecting with a read in flight.
    pat_mode = 0;
    wr(2'd0, 4'hF, 32'h0000_0005, 0);
    repeat (10) @(negedge clk);
    bus_addr = 2'd1; bus_re = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus_re = 1'b0; rst = 1'b0;
    chk("rst_mid_rvalid", 32'(bus_rvalid), 32'd0);
    chk("rst_mid_rdata", bus_rdata, 32'd0);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    rd(2'd1, "post_rst_status", 0, d);
    chk("post_rst_status_val", d, 32'd0);
    rd(2'd0, "post_rst_ctrl", 0, d);
    chk("post_rst_ctrl_val", d, 32'd0);
    rd(2'd2, "post_rst_data", 0, d);
    chk("post_rst_data_val", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
